// File: rtl/shift_add_mult_ctrl.sv
// Sequencer for a shift-add multiplier datapath (A = partial product,
// Q = multiplier, M = multiplicand). Runs N add/shift iterations after a
// start request and pulses done when A:Q holds the product.
module shift_add_mult_ctrl #(
  parameter int N  = 8,
  parameter int CW = $clog2(N + 1)
) (
  input  logic clk,
  input  logic clr,
  input  logic start,
  input  logic q0,
  input  logic add_cout,
  output logic a_clr,
  output logic a_ld,
  output logic a_sft,
  output logic a_sin,
  output logic q_ld,
  output logic q_sft,
  output logic m_ld,
  output logic busy,
  output logic done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic            carry_reg;

  // State sequencing, iteration counter and stored adder carry.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) state_reg <= INIT;
        end
        INIT: begin
          cnt_reg   <= CW'(N);
          carry_reg <= 1'b0;
          state_reg <= ADD;
        end
        ADD: begin
          // Only a real add (q0=1) produces a carry to shift into A.
          carry_reg <= q0 & add_cout;
          state_reg <= SHIFT;
        end
        SHIFT: begin
          carry_reg <= 1'b0;
          cnt_reg   <= cnt_reg - CW'(1);
          // cnt==1 means this shift was the last one; never wraps below 1.
          if (cnt_reg == CW'(1)) state_reg <= DONE;
          else                   state_reg <= ADD;
        end
        DONE: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from the state register; a_ld also gated by the multiplier LSB.
  assign a_clr = (state_reg == INIT);
  assign q_ld  = (state_reg == INIT);
  assign m_ld  = (state_reg == INIT);
  assign a_ld  = (state_reg == ADD) & q0;
  assign a_sft = (state_reg == SHIFT);
  assign q_sft = (state_reg == SHIFT);
  assign a_sin = carry_reg;
  assign busy  = (state_reg != IDLE);
  assign done  = (state_reg == DONE);

endmodule
